// File: rtl/note_hit_judge_pkg.sv
// Shared definitions for the note hit judge: FSM states, multiplier cap and
// default scoring constants so the scoreboard and display logic agree.
package note_hit_judge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } judge_state_e;

  localparam int unsigned MULT_CAP        = 4;
  localparam int unsigned DEF_BASE_POINTS = 10;
  localparam int unsigned DEF_STEP        = 8;

  // Combo multiplier: 1 + combo/step, capped at MULT_CAP.
  function automatic logic [2:0] mult_of(input int unsigned combo, input int unsigned step);
    int unsigned m;
    m = 1 + combo / step;
    if (m > MULT_CAP) m = MULT_CAP;
    return 3'(m);
  endfunction

endpackage

// File: rtl/note_hit_judge_if.sv
// Game-side signal bundle for one lane judge: control/press inputs plus
// score, combo, multiplier and event-pulse outputs.
interface note_hit_judge_if #(
  parameter int unsigned SCORE_W = 16,
  parameter int unsigned COMBO_W = 8
);
  logic               ENABLE;
  logic               TICK;
  logic               NOTE_ZONE;
  logic               PLAY_N;
  logic [SCORE_W-1:0] SCORE;
  logic [COMBO_W-1:0] COMBO;
  logic [2:0]         MULT;
  logic               HIT_PULSE;
  logic               MISS_PULSE;
  logic               GHOST_PULSE;

  modport master (
    output ENABLE, TICK, NOTE_ZONE, PLAY_N,
    input  SCORE, COMBO, MULT, HIT_PULSE, MISS_PULSE, GHOST_PULSE
  );

  modport slave (
    input  ENABLE, TICK, NOTE_ZONE, PLAY_N,
    output SCORE, COMBO, MULT, HIT_PULSE, MISS_PULSE, GHOST_PULSE
  );
endinterface

// File: rtl/note_hit_judge_button_sync_edge.sv
// Two-flop synchroniser for an active-low KEY input followed by a registered
// falling-edge detector; press_o is a single-cycle pulse 3 clocks after the pin falls.
module button_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_ni,
  output logic press_o
);
  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic press_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      prev_q  <= 1'b1;
      press_q <= 1'b0;
    end else begin
      meta_q  <= btn_ni;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      press_q <= prev_q & ~sync_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/note_hit_judge.sv
// Single-lane note judge: samples the hit-zone bit on each game tick, judges
// strums as hit/miss/ghost and keeps score, combo and the combo multiplier.
module note_hit_judge
  import note_hit_judge_pkg::*;
#(
  parameter int unsigned SCORE_W     = 16,
  parameter int unsigned COMBO_W     = 8,
  parameter int unsigned BASE_POINTS = DEF_BASE_POINTS,
  parameter int unsigned STEP        = DEF_STEP
) (
  input logic             CLK,
  input logic             RESET_N,
  note_hit_judge_if.slave io
);
  localparam int unsigned SUM_W = SCORE_W + 1;

  judge_state_e       state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [COMBO_W-1:0] combo_q, combo_d;
  logic [2:0]         mult_q, mult_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;
  logic               ghost_q, ghost_d;
  logic               press;
  logic [SUM_W-1:0]   sum;
  logic [2:0]         cur_mult;

  button_sync_edge u_play (
    .clk_i   (CLK),
    .rst_ni  (RESET_N),
    .btn_ni  (io.PLAY_N),
    .press_o (press)
  );

  always_ff @(posedge CLK) begin
    if (!RESET_N) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Press is resolved first; the tick then sees the post-press state, so a
  // hit on the outgoing note suppresses its miss and the new note still arms.
  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    combo_d  = combo_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    ghost_d  = 1'b0;
    sum      = '0;
    cur_mult = mult_of(32'(combo_q), STEP);
    mult_d   = cur_mult;

    if (io.ENABLE) begin
      if (press) begin
        if (state_q == ST_ARMED) begin
          sum     = {1'b0, score_q} + SUM_W'(BASE_POINTS * cur_mult);
          score_d = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
          if (combo_q != '1) combo_d = combo_q + COMBO_W'(1);
          state_d = ST_DONE;
          hit_d   = 1'b1;
        end else begin
          combo_d = '0;
          ghost_d = 1'b1;
        end
      end
      if (io.TICK) begin
        if (state_d == ST_ARMED) begin
          miss_d  = 1'b1;
          combo_d = '0;
        end
        state_d = io.NOTE_ZONE ? ST_ARMED : ST_IDLE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      score_q <= '0;
      combo_q <= '0;
      mult_q  <= 3'd1;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      ghost_q <= 1'b0;
    end else begin
      score_q <= score_d;
      combo_q <= combo_d;
      mult_q  <= mult_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      ghost_q <= ghost_d;
    end
  end

  assign io.SCORE       = score_q;
  assign io.COMBO       = combo_q;
  assign io.MULT        = mult_q;
  assign io.HIT_PULSE   = hit_q;
  assign io.MISS_PULSE  = miss_q;
  assign io.GHOST_PULSE = ghost_q;

endmodule
